multiplier_param: RTL and testbench



---
 rtl/multiplier_param.sv | 105 ++++++++++
 tb/tb_multiplier_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_param.sv
// multiplier_param: sequential shift-add unsigned multiplier
// One partial product per clock; strt/idle handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   strt         start request, sampled only while idle
//   multiplicand operand A, captured on the strt edge
//   multiplier   operand B, captured on the strt edge
//   product      registered result, held until next completion
//   done         one-cycle pulse when a new product is visible
//   idle         high while ready to accept strt
//
// Optional: define MULT_EARLY_EXIT_EN to stop calculating once no
// multiplier bits remain set (data-dependent latency).
module multiplier_param #(
    parameter int BITSIZE   = 16,
    parameter int INDEXSIZE = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   strt,
    input  logic [BITSIZE-1:0]     multiplicand,
    input  logic [BITSIZE-1:0]     multiplier,
    output logic [2*BITSIZE-1:0]   product,
    output logic                   done,
    output logic                   idle
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        CALC     = 2'b01,
        POSTCALC = 2'b10
    } state_t;

    localparam logic [INDEXSIZE-1:0] LAST_CNT =
        INDEXSIZE'(BITSIZE - 1);

    state_t                 state;
    logic [2*BITSIZE-1:0]   mcand_reg;
    logic [BITSIZE-1:0]     mplier_reg;
    logic [2*BITSIZE-1:0]   acc;
    logic [INDEXSIZE-1:0]   cnt;

    logic [2*BITSIZE-1:0]   partial;
    logic                   calc_last;
    logic                   zero_op;

    assign idle    = (state == IDLE);
    assign zero_op = (multiplicand == '0) || (multiplier == '0);
    assign partial = mplier_reg[0] ? mcand_reg : '0;

`ifdef MULT_EARLY_EXIT_EN
    // Current bit 0 is still added this cycle; nothing above it
    // remains, so this is the final useful iteration.
    assign calc_last = (cnt == LAST_CNT) ||
                       (mplier_reg[BITSIZE-1:1] == '0);
`else
    assign calc_last = (cnt == LAST_CNT);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc        <= '0;
            cnt        <= '0;
            product    <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (strt) begin
                        mcand_reg  <= {{BITSIZE{1'b0}}, multiplicand};
                        mplier_reg <= multiplier;
                        acc        <= '0;
                        cnt        <= '0;
                        // A zero operand already yields acc == 0.
                        state      <= zero_op ? POSTCALC : CALC;
                    end
                end
                CALC: begin
                    acc        <= acc + partial;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt        <= cnt + 1'b1;
                    if (calc_last) begin
                        state <= POSTCALC;
                    end
                end
                POSTCALC: begin
                    product <= acc;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_param.sv
// tb_multiplier_param: directed vectors for multiplier_param
// Table-driven products plus hand-written corner sequences.
module tb_multiplier_param;

    localparam int N = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           strt = 1'b0;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   b = '0;
    logic [2*N-1:0] product;
    logic           done;
    logic           idle;

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    multiplier_param #(
        .BITSIZE   (N),
        .INDEXSIZE (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .strt         (strt),
        .multiplicand (a),
        .multiplier   (b),
        .product      (product),
        .done         (done),
        .idle         (idle)
    );

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] p;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Clocks from the strt edge to done being visible.
    function automatic int exp_lat(input logic [N-1:0] x,
                                   input logic [N-1:0] y);
        int m;
        m = 0;
        if (x == '0 || y == '0) return 1;
`ifdef MULT_EARLY_EXIT_EN
        for (int i = 0; i < N; i++) if (y[i]) m = i;
        return m + 2;
`else
        return m + N + 1;
`endif
    endfunction

    // Called #1 after a posedge with the DUT idle.
    task automatic run(input logic [N-1:0] x,
                       input logic [N-1:0] y,
                       output int lat);
        a = x;
        b = y;
        strt = 1'b1;
        @(posedge clk);
        #1 strt = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int ndone;
        int t1;
        int t2;

        tbl[0]  = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        tbl[1]  = '{16'd1234, 16'd5678, 32'h006AE9BC};
        tbl[2]  = '{16'h007B, 16'h0000, 32'h00000000};
        tbl[3]  = '{16'h0000, 16'hFFFF, 32'h00000000};
        tbl[4]  = '{16'h0003, 16'h0005, 32'h0000000F};
        tbl[5]  = '{16'h1234, 16'h0010, 32'h00012340};
        tbl[6]  = '{16'h0001, 16'h0001, 32'h00000001};
        tbl[7]  = '{16'h8000, 16'h8000, 32'h40000000};
        tbl[8]  = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
        tbl[9]  = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
        tbl[10] = '{16'h0002, 16'h8000, 32'h00010000};
        tbl[11] = '{16'hAAAA, 16'h5555, 32'h38E31C72};

        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("rst_product", product, 0);
        chk("rst_done", done, 0);
        chk("rst_idle", idle, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Table of products
        for (int i = 0; i < 12; i++) begin
            run(tbl[i].a, tbl[i].b, lat);
            chk($sformatf("lat[%0d]", i), lat, exp_lat(tbl[i].a, tbl[i].b));
            chk($sformatf("prod[%0d]", i), product, tbl[i].p);
            chk($sformatf("idle_at_done[%0d]", i), idle, 1);
            @(posedge clk);
            #1;
            chk($sformatf("done_pulse[%0d]", i), done, 0);
        end

        // Result held while idle
        run(16'd1234, 16'd5678, lat);
        chk("hold_lat", lat, exp_lat(16'd1234, 16'd5678));
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("hold_product", product, 32'h006AE9BC);
            chk("hold_done", done, 0);
        end

        // strt and operand changes during CALC are ignored
        a = 16'h1234;
        b = 16'h0010;
        strt = 1'b1;
        @(posedge clk);
        #1 strt = 1'b0;
        lat = 0;
        ndone = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin
                strt = 1'b1;
                a = 16'hFFFF;
                b = 16'hFFFF;
            end
            if (k == 4) begin
                strt = 1'b0;
                a = 16'h5A5A;
                b = 16'h0F0F;
            end
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = k;
                    chk("ign_product", product, 32'h00012340);
                end
            end
        end
        chk("ign_lat", lat, exp_lat(16'h1234, 16'h0010));
        chk("ign_ndone", ndone, 1);

        // Reset in the middle of a calculation
        a = 16'hFFFF;
        b = 16'hFFFF;
        strt = 1'b1;
        @(posedge clk);
        #1 strt = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_product", product, 0);
        chk("abort_done", done, 0);
        chk("abort_idle", idle, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_ndone", ndone, 0);
        run(16'd3, 16'd5, lat);
        chk("after_abort_lat", lat, exp_lat(16'd3, 16'd5));
        chk("after_abort_product", product, 15);
        @(posedge clk);
        #1;

        // strt held high: one result per latency+1 clocks
        a = 16'd3;
        b = 16'd5;
        strt = 1'b1;
        t1 = 0;
        t2 = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                chk("b2b_product", product, 15);
                if (t1 == 0) begin
                    t1 = k;
                end else begin
                    t2 = k;
                    break;
                end
            end
        end
        strt = 1'b0;
        chk("b2b_first", t1, exp_lat(16'd3, 16'd5) + 1);
        chk("b2b_gap", t2 - t1, exp_lat(16'd3, 16'd5) + 1);
        @(posedge clk);
        #1;
        chk("b2b_stop_idle", idle, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
